ras_spec: RTL and testbench
===========================

// Module: ras_spec
// PURPOSE
//  Speculative return-address stack for the scalar front-end. Next generation of the RAS: parametrised address
//  width and depth, checkpoint queue that saves the top-of-stack entry itself, exact occupancy counting,
//  push+pop replace (tail-call), underflow protection.
//  Sits beside the branch predictor. Supplies predicted return targets and is repaired on mispredict flush.
// PARAMETERS
//  DEPTH       8   stack entries (power of 2, >=2)
//  AW          32  address width
//  LSB_DROP    2   low address bits not stored (1 with compressed ISA); stored width SW = AW-LSB_DROP
//  CKPT_DEPTH  4   outstanding branch checkpoints (power of 2)
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   asynchronous reset, active-high
//  flush         in   1                   mispredict: restore oldest checkpoint
//  ckpt_push     in   1                   unresolved branch issued: snapshot state
//  ckpt_release  in   1                   oldest branch resolved correctly: drop its checkpoint
//  push          in   1                   call: push push_addr
//  pop           in   1                   return: pop top
//  push_addr     in   AW                  return address to push
//  top_addr      out  AW                  predicted return target; 0 when empty
//  empty         out  1                   count==0
//  full          out  1                   count==DEPTH
//  count         out  $clog2(DEPTH+1)     occupancy
//  ckpt_valid    out  1                   >=1 checkpoint held
//  ckpt_full     out  1                   CKPT_DEPTH checkpoints held (front-end stalls ckpt_push)
// BEHAVIOUR
//  - Reset: head=0, count=0, ckpt queue empty. Outputs: top_addr=0, empty=1, full=0, count=0, ckpt_valid=0,
//    ckpt_full=0. Stack RAM is not reset. Reset mid-operation discards all state immediately.
//  - Outputs are combinational from registered state. Updates are visible the cycle after the event.
//  - top_addr = {buf[head-1], LSB_DROP'b0} when count>0, else 0. Pointer arithmetic is mod DEPTH.
//  - Priority each cycle: flush > (push/pop). ckpt_push/ckpt_release are evaluated alongside push/pop.
//  - flush with ckpt_valid: head, count <= oldest ckpt. buf[ckpt.head-1] <= ckpt.top (skipped if ckpt.count==0).
//    Checkpoint queue is cleared. push/pop/ckpt_* that cycle are ignored.
//  - flush without ckpt_valid: stack unchanged. push/pop/ckpt_* that cycle are ignored.
//  - push only: buf[head] <= push_addr[AW-1:LSB_DROP]; head++. count++ unless full; if full, the oldest entry is
//    silently overwritten and count stays DEPTH.
//  - pop only: if count>0 then head--, count--. If empty, ignored (no underflow).
//  - push & pop: count>0 -> buf[head-1] <= push_addr, head/count unchanged. count==0 -> acts as push only.
//  - ckpt_push: enqueue {head, count, top SW bits} sampled BEFORE this cycle's push/pop.
//    Ignored when ckpt_full, unless ckpt_release is in the same cycle (then both happen).
//  - ckpt_release: dequeue oldest. Ignored when queue empty (a same-cycle ckpt_push into an empty queue is still
//    enqueued).
//  - Checkpoint queue is in-order FIFO; pointers wrap mod CKPT_DEPTH with an extra wrap bit for full/empty.
// STRUCTURE
//  - ras_pkg: default DEPTH/AW/LSB_DROP/CKPT_DEPTH localparams; ras_op_e {RAS_NOP, RAS_PUSH, RAS_POP,
//    RAS_REPL} used for decode.
//  - Checkpoint record is a packed struct built inside the module (parameter-dependent widths).
//  - Sub-module ras_ckpt_fifo: the parametrised checkpoint queue (push/pop/clear, valid/full, async rst).
//  - Top level: stack RAM, head/count registers, op decode, flush repair mux.
// TESTING (DEPTH=4, AW=32, LSB_DROP=2, CKPT_DEPTH=4)
//  1. Reset; push 0x1000, push 0x2000 -> top 0x2000, count 2. Pop -> 0x1000. Pop -> empty=1, top 0.
//     Pop again -> count 0, no change.
//  2. Push 0x10,0x20,0x30,0x40,0x50 -> full=1, count 4, top 0x50. Pops return 0x40,0x30,0x20, then empty.
//     0x10 is lost.
//  3. Stack [0x1000,0x2000]; push 0x3000 & pop same cycle -> top 0x3000, count 2. Pop -> top 0x1000.
//  4. Stack [0x1000,0x2000]; ckpt_push; pop; push 0x9000 (overwrites slot 1); flush -> top 0x2000, count 2,
//     ckpt_valid 0.
//  5. ckpt A at count 1, push 0x2000, ckpt B at count 2, push 0x3000; ckpt_release; flush -> count 2, top 0x2000.
//     flush with no ckpt -> unchanged.
//  6. Four ckpt_push -> ckpt_full=1. Fifth ignored. 5th with ckpt_release -> still full. Assert rst mid-push ->
//     all outputs at reset values the same cycle.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared defaults and the push/pop operation decode for the return-address stack.
package ras_pkg;

  localparam int unsigned RAS_DEPTH      = 8;
  localparam int unsigned RAS_AW         = 32;
  localparam int unsigned RAS_LSB_DROP   = 2;
  localparam int unsigned RAS_CKPT_DEPTH = 4;

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_REPL
  } ras_op_e;

  // A same-cycle push+pop on an empty stack degrades to a plain push; a pop on empty is dropped.
  function automatic ras_op_e ras_decode(input logic push, input logic pop, input logic nonempty);
    if (push && pop && nonempty) return RAS_REPL;
    if (push)                    return RAS_PUSH;
    if (pop && nonempty)         return RAS_POP;
    return RAS_NOP;
  endfunction

endpackage

// File: rtl/ras_ckpt_fifo.sv
// In-order checkpoint queue; wrap-bit pointers distinguish full from empty.
module ras_ckpt_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign valid   = wr_ptr != rd_ptr;
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && valid;
  // A release in the same cycle frees a slot, so a push against a full queue still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/ras_spec.sv
// Speculative return-address stack with checkpoint-based repair on mispredict flush.
module ras_spec
  import ras_pkg::*;
#(
  parameter int unsigned DEPTH      = RAS_DEPTH,
  parameter int unsigned AW         = RAS_AW,
  parameter int unsigned LSB_DROP   = RAS_LSB_DROP,
  parameter int unsigned CKPT_DEPTH = RAS_CKPT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       ckpt_push,
  input  logic                       ckpt_release,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              push_addr,
  output logic [AW-1:0]              top_addr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ckpt_valid,
  output logic                       ckpt_full
);

  localparam int unsigned HW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = AW - LSB_DROP;

  typedef struct packed {
    logic [HW-1:0] head;
    logic [CW-1:0] count;
    logic [SW-1:0] top;
  } ckpt_t;

  logic [SW-1:0] stack_mem [DEPTH];
  logic [HW-1:0] head;
  logic [HW-1:0] head_prev;
  logic [HW-1:0] head_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [SW-1:0] top_entry;
  logic          mem_we;
  logic [HW-1:0] mem_waddr;
  logic [SW-1:0] mem_wdata;
  ckpt_t         snap;
  ckpt_t         restore;
  logic [$bits(ckpt_t)-1:0] fifo_dout;
  ras_op_e       op;
  logic          unused_lsbs;

  assign unused_lsbs = ^push_addr[LSB_DROP-1:0];

  assign head_prev = head - HW'(1);
  assign top_entry = stack_mem[head_prev];
  assign count     = count_q;
  assign empty     = count_q == '0;
  assign full      = count_q == CW'(DEPTH);
  assign top_addr  = empty ? '0 : {top_entry, {LSB_DROP{1'b0}}};

  // Snapshot is taken from pre-update state so the restore undoes this cycle's push/pop too.
  assign snap    = '{head: head, count: count_q, top: top_entry};
  assign restore = ckpt_t'(fifo_dout);
  assign op      = ras_decode(push, pop, !empty);

  ras_ckpt_fifo #(
    .W     ($bits(ckpt_t)),
    .DEPTH (CKPT_DEPTH)
  ) u_ckpt (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (ckpt_push && !flush),
    .pop   (ckpt_release && !flush),
    .din   (snap),
    .dout  (fifo_dout),
    .valid (ckpt_valid),
    .full  (ckpt_full)
  );

  // Only the top slot is repaired on flush; deeper slots are assumed intact.
  always_comb begin
    head_d    = head;
    count_d   = count_q;
    mem_we    = 1'b0;
    mem_waddr = head;
    mem_wdata = push_addr[AW-1:LSB_DROP];
    if (flush) begin
      if (ckpt_valid) begin
        head_d    = restore.head;
        count_d   = restore.count;
        mem_we    = restore.count != '0;
        mem_waddr = restore.head - HW'(1);
        mem_wdata = restore.top;
      end
    end else begin
      unique case (op)
        RAS_PUSH: begin
          mem_we = 1'b1;
          head_d = head + HW'(1);
          if (!full) count_d = count_q + CW'(1);
        end
        RAS_POP: begin
          head_d  = head_prev;
          count_d = count_q - CW'(1);
        end
        RAS_REPL: begin
          mem_we    = 1'b1;
          mem_waddr = head_prev;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      count_q <= '0;
    end else begin
      head    <= head_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) stack_mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_ras_spec.sv
// Directed and randomized checks of ras_spec against a slot-level behavioural model.
module tb_ras_spec;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, ckpt_push, ckpt_release, push, pop;
  logic [31:0] push_addr;
  logic [31:0] top_addr;
  logic        empty, full, ckpt_valid, ckpt_full;
  logic [2:0]  count;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic        chk_en      = 1'b0;

  typedef struct {
    int          head;
    int          cnt;
    logic [29:0] top;
  } mck_t;

  logic [29:0] m_mem [4];
  int          m_head;
  int          m_cnt;
  mck_t        ckq[$];

  ras_spec #(
    .DEPTH      (4),
    .AW         (32),
    .LSB_DROP   (2),
    .CKPT_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .ckpt_push    (ckpt_push),
    .ckpt_release (ckpt_release),
    .push         (push),
    .pop          (pop),
    .push_addr    (push_addr),
    .top_addr     (top_addr),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .ckpt_valid   (ckpt_valid),
    .ckpt_full    (ckpt_full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_top();
    if (m_cnt == 0) return 32'h0;
    return {m_mem[(m_head + 3) % 4], 2'b00};
  endfunction

  function automatic void model_reset();
    m_head = 0;
    m_cnt  = 0;
    ckq.delete();
  endfunction

  function automatic void model_step(input logic f, input logic cp, input logic cr,
                                     input logic pu, input logic po, input logic [31:0] a);
    mck_t c;
    bit   rel_ok;
    if (f) begin
      if (ckq.size() > 0) begin
        c      = ckq[0];
        m_head = c.head;
        m_cnt  = c.cnt;
        if (c.cnt > 0) m_mem[(c.head + 3) % 4] = c.top;
      end
      ckq.delete();
      return;
    end
    c.head = m_head;
    c.cnt  = m_cnt;
    c.top  = m_mem[(m_head + 3) % 4];
    rel_ok = cr && (ckq.size() > 0);
    if (rel_ok) void'(ckq.pop_front());
    if (cp && (ckq.size() < 4)) ckq.push_back(c);
    if (pu && po && m_cnt > 0) begin
      m_mem[(m_head + 3) % 4] = a[31:2];
    end else if (pu) begin
      m_mem[m_head] = a[31:2];
      m_head = (m_head + 1) % 4;
      if (m_cnt < 4) m_cnt++;
    end else if (po && m_cnt > 0) begin
      m_head = (m_head + 3) % 4;
      m_cnt--;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("top_addr",   top_addr,         m_top());
      chk("empty",      32'(empty),       32'(m_cnt == 0));
      chk("full",       32'(full),        32'(m_cnt == 4));
      chk("count",      32'(count),       32'(m_cnt));
      chk("ckpt_valid", 32'(ckpt_valid),  32'(ckq.size() > 0));
      chk("ckpt_full",  32'(ckpt_full),   32'(ckq.size() == 4));
    end
  end

  task automatic step(input logic f, input logic cp, input logic cr,
                      input logic pu, input logic po, input logic [31:0] a);
    flush = f; ckpt_push = cp; ckpt_release = cr; push = pu; pop = po; push_addr = a;
    @(posedge clk);
    model_step(f, cp, cr, pu, po, a);
    @(negedge clk);
  endtask

  task automatic do_push(input logic [31:0] a); step(0, 0, 0, 1, 0, a); endtask
  task automatic do_pop();                      step(0, 0, 0, 0, 1, 32'h0); endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 0; ckpt_push = 0; ckpt_release = 0; push = 0; pop = 0; push_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_top",   top_addr,   32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: basic push/pop and underflow
    do_push(32'h1000); do_push(32'h2000);
    chk("t1_top2", top_addr, 32'h2000);
    chk("t1_cnt2", 32'(count), 32'd2);
    do_pop();  chk("t1_pop1", top_addr, 32'h1000);
    do_pop();  chk("t1_empty", 32'(empty), 32'd1); chk("t1_top0", top_addr, 32'h0);
    do_pop();  chk("t1_underflow", 32'(count), 32'd0);

    // 2: overflow overwrites oldest
    do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40); do_push(32'h50);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_cnt",  32'(count), 32'd4);
    chk("t2_top",  top_addr, 32'h50);
    do_pop(); chk("t2_p1", top_addr, 32'h40);
    do_pop(); chk("t2_p2", top_addr, 32'h30);
    do_pop(); chk("t2_p3", top_addr, 32'h20);
    do_pop(); chk("t2_empty", 32'(empty), 32'd1);

    // 3: push+pop replace
    do_push(32'h1000); do_push(32'h2000);
    step(0, 0, 0, 1, 1, 32'h3000);
    chk("t3_repl_top", top_addr, 32'h3000);
    chk("t3_repl_cnt", 32'(count), 32'd2);
    do_pop(); chk("t3_after", top_addr, 32'h1000);
    do_pop();

    // 4: flush repairs the overwritten top slot
    do_push(32'h1000); do_push(32'h2000);
    step(0, 1, 0, 0, 0, 32'h0);
    do_pop(); do_push(32'h9000);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("t4_top",  top_addr, 32'h2000);
    chk("t4_cnt",  32'(count), 32'd2);
    chk("t4_cv",   32'(ckpt_valid), 32'd0);
    do_pop(); do_pop();

    // 5: release drops oldest; flush restores the next; flush without ckpt is inert
    do_push(32'h1000);
    step(0, 1, 0, 0, 0, 32'h0);
    do_push(32'h2000);
    step(0, 1, 0, 0, 0, 32'h0);
    do_push(32'h3000);
    step(0, 0, 1, 0, 0, 32'h0);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("t5_cnt", 32'(count), 32'd2);
    chk("t5_top", top_addr, 32'h2000);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("t5_noop_cnt", 32'(count), 32'd2);
    chk("t5_noop_top", top_addr, 32'h2000);

    // 6: checkpoint full handling, then asynchronous reset
    repeat (4) step(0, 1, 0, 0, 0, 32'h0);
    chk("t6_full4", 32'(ckpt_full), 32'd1);
    step(0, 1, 0, 0, 0, 32'h0);
    chk("t6_full5", 32'(ckpt_full), 32'd1);
    step(0, 1, 1, 0, 0, 32'h0);
    chk("t6_full_rel", 32'(ckpt_full), 32'd1);
    push = 1'b1; push_addr = 32'h7000;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_top",  top_addr,         32'h0);
    chk("t6_rst_emp",  32'(empty),       32'd1);
    chk("t6_rst_full", 32'(full),        32'd0);
    chk("t6_rst_cnt",  32'(count),       32'd0);
    chk("t6_rst_cv",   32'(ckpt_valid),  32'd0);
    chk("t6_rst_cf",   32'(ckpt_full),   32'd0);
    push = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) < 4,  $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 40, $urandom);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
